// File: rtl/multi_tacho_timer_pkg.sv
// Shared constants and helpers for the multi-channel fan tachometer.
package multi_tacho_timer_pkg;

   localparam int unsigned NUM_CH_DEF     = 4;
   localparam int unsigned CNT_W_DEF      = 8;
   localparam int unsigned AVG_LOG2_DEF   = 1;
   localparam int unsigned FILT_LEN_DEF   = 3;
   localparam int unsigned STALL_SECS_DEF = 3;
   localparam int unsigned ZS_W           = 4;

   typedef logic [ZS_W-1:0] zero_secs_t;

   // Saturating zero-second run length; any nonzero second restarts the run.
   function automatic zero_secs_t zs_next(input zero_secs_t zs, input logic is_zero);
      if (!is_zero) return '0;
      return (zs == '1) ? zs : zs + ZS_W'(1);
   endfunction

endpackage

// File: rtl/multi_tacho_timer_if.sv
// Gate, enable, tacho inputs and averaged/stall outputs of the tachometer.
interface multi_tacho_timer_if #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned CNT_W  = 8
);
   logic                    one_hz;
   logic [NUM_CH-1:0]       ch_enable;
   logic [NUM_CH-1:0]       tacho;
   logic [NUM_CH*CNT_W-1:0] pulses_per_second;
   logic [NUM_CH-1:0]       stall;
   logic                    update;

   modport master (
      output one_hz, ch_enable, tacho,
      input  pulses_per_second, stall, update
   );

   modport slave (
      input  one_hz, ch_enable, tacho,
      output pulses_per_second, stall, update
   );
endinterface

// File: rtl/multi_tacho_timer_tacho_channel.sv
// One tacho channel: synchroniser, glitch filter, edge counter, averaging
// history and stall detection.
module tacho_channel
   import multi_tacho_timer_pkg::*;
#(
   parameter int unsigned CNT_W      = CNT_W_DEF,
   parameter int unsigned AVG_LOG2   = AVG_LOG2_DEF,
   parameter int unsigned FILT_LEN   = FILT_LEN_DEF,
   parameter int unsigned STALL_SECS = STALL_SECS_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             one_hz,
   input  logic             enable,
   input  logic             tacho,
   output logic [CNT_W-1:0] pps,
   output logic             stall
);

   localparam int unsigned DEPTH = 1 << AVG_LOG2;
   localparam int unsigned SUM_W = CNT_W + AVG_LOG2;
   localparam int unsigned FC_W  = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [1:0]                  sync;
   logic                        filt;
   logic [FC_W-1:0]             run_cnt;
   logic                        edge_pulse;
   logic [CNT_W-1:0]            count;
   logic [DEPTH-1:0][CNT_W-1:0] hist;
   zero_secs_t                  zero_secs;

   logic                        filt_flip_c;
   logic [SUM_W-1:0]            win_sum_c;
   zero_secs_t                  zs_nxt_c;

   assign filt_flip_c = (sync[1] != filt) && (run_cnt == FC_W'(FILT_LEN - 1));

   // Synchroniser presets idle-high like the filter so release never makes an edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync       <= 2'b11;
         filt       <= 1'b1;
         run_cnt    <= '0;
         edge_pulse <= 1'b0;
      end else begin
         sync       <= {sync[0], tacho};
         edge_pulse <= filt_flip_c && filt;
         if (filt_flip_c) begin
            filt    <= sync[1];
            run_cnt <= '0;
         end else if (sync[1] != filt) begin
            run_cnt <= run_cnt + FC_W'(1);
         end else begin
            run_cnt <= '0;
         end
      end
   end

   // Window sum as it will be after this gate's push: current count plus the newest DEPTH-1 entries.
   always_comb begin
      win_sum_c = SUM_W'(count);
      for (int unsigned i = 1; i < DEPTH; i++) begin
         win_sum_c = win_sum_c + SUM_W'(hist[i-1]);
      end
   end

   assign zs_nxt_c = zs_next(zero_secs, count == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count     <= '0;
         hist      <= '0;
         zero_secs <= '0;
         pps       <= '0;
         stall     <= 1'b0;
      end else if (!enable) begin
         count     <= '0;
         hist      <= '0;
         zero_secs <= '0;
         pps       <= '0;
         stall     <= 1'b0;
      end else if (one_hz) begin
         // An edge landing on the gate belongs to the new second.
         count   <= edge_pulse ? CNT_W'(1) : '0;
         hist[0] <= count;
         for (int unsigned i = 1; i < DEPTH; i++) begin
            hist[i] <= hist[i-1];
         end
         zero_secs <= zs_nxt_c;
         pps       <= CNT_W'(win_sum_c >> AVG_LOG2);
         stall     <= (zs_nxt_c >= ZS_W'(STALL_SECS));
      end else if (edge_pulse && (count != CNT_MAX)) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/multi_tacho_timer.sv
// Multi-channel fan tachometer: per-channel averaged pulse rate and stall flag,
// refreshed once per one_hz gate.
module multi_tacho_timer
   import multi_tacho_timer_pkg::*;
#(
   parameter int unsigned NUM_CH     = NUM_CH_DEF,
   parameter int unsigned CNT_W      = CNT_W_DEF,
   parameter int unsigned AVG_LOG2   = AVG_LOG2_DEF,
   parameter int unsigned FILT_LEN   = FILT_LEN_DEF,
   parameter int unsigned STALL_SECS = STALL_SECS_DEF
) (
   input logic                clk,
   input logic                reset,
   multi_tacho_timer_if.slave bus
);

   logic [NUM_CH*CNT_W-1:0] pps;
   logic [NUM_CH-1:0]       stall;
   logic                    update;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      tacho_channel #(
         .CNT_W      (CNT_W),
         .AVG_LOG2   (AVG_LOG2),
         .FILT_LEN   (FILT_LEN),
         .STALL_SECS (STALL_SECS)
      ) u_ch (
         .clk    (clk),
         .reset  (reset),
         .one_hz (bus.one_hz),
         .enable (bus.ch_enable[c]),
         .tacho  (bus.tacho[c]),
         .pps    (pps[c*CNT_W +: CNT_W]),
         .stall  (stall[c])
      );
   end

   // Strobe aligns with the channel outputs registered on the gate.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) update <= 1'b0;
      else        update <= bus.one_hz;
   end

   assign bus.pulses_per_second = pps;
   assign bus.stall             = stall;
   assign bus.update            = update;

endmodule
